// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter between the
// instruction-fetch port and the data port.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] WEB_NONE = 4'hF;

  // Which port owns the SRAM read data presented this cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_DM = 2'd2
  } resp_tag_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data requests: data wins unless fetch has
// been denied STARVE_MAX consecutive cycles while requesting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  output logic if_grant,
  output logic dm_grant
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          starved;

  always_comb begin
    starved      = (starve_cnt_q == MAX_C);
    // No grants while reset is held, so stalls mirror the requests.
    if_grant     = rst_n & if_req & (~dm_req | starved);
    dm_grant     = rst_n & dm_req & ~if_grant;
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_grant) begin
      starve_cnt_d = '0;
    end else if (dm_grant && !starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and data ports,
// routing 1-cycle-latency read data back to whichever port issued the read.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid,
  output logic              dm_stall,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do,
  output resp_tag_e         dbg_tag
);

  // Request/stall handshake: a port raising req is served in the cycle its
  // stall output is low; while stall is high it must keep req, addr and data
  // stable. Read data arrives one cycle after the serving cycle with rvalid.

  logic if_grant;
  logic dm_grant;

  resp_tag_e         tag_q, tag_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] dm_hold_q, dm_hold_d;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .if_grant(if_grant),
    .dm_grant(dm_grant)
  );

  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = WEB_NONE;
    sram_a   = '0;
    sram_di  = '0;
    tag_d    = IDLE;
    if (dm_grant) begin
      sram_cs = 1'b1;
      sram_a  = dm_addr;
      if (dm_we) begin
        sram_web = ~dm_wen;
        sram_di  = dm_wdata;
      end else begin
        sram_oe = 1'b1;
        tag_d   = RESP_DM;
      end
    end else if (if_grant) begin
      sram_cs = 1'b1;
      sram_a  = if_addr;
      sram_oe = 1'b1;
      tag_d   = RESP_IF;
    end
  end

  // Hold registers keep the last returned word visible while the pipeline stalls.
  always_comb begin
    if_rvalid = (tag_q == RESP_IF);
    dm_rvalid = (tag_q == RESP_DM);
    if_rdata  = if_rvalid ? sram_do : if_hold_q;
    dm_rdata  = dm_rvalid ? sram_do : dm_hold_q;
    if_hold_d = if_rdata;
    dm_hold_d = dm_rdata;
    if_stall  = if_req & ~if_grant;
    dm_stall  = dm_req & ~dm_grant;
    dbg_tag   = tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q     <= IDLE;
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      tag_q     <= tag_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port SRAM
// (read data registered one cycle after the access).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_wen;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_rvalid;
  logic          dm_stall;
  logic          sram_cs;
  logic          sram_oe;
  logic [3:0]    sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do = '0;
  resp_tag_e     dbg_tag;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // clock / reset block
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_rvalid(if_rvalid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wen(dm_wen), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .dm_stall(dm_stall),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
    .dbg_tag(dbg_tag)
  );

  // SRAM model: registered read data, byte writes on active-low enables
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_oe) begin
        sram_do <= mem[sram_a];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!sram_web[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_wen   = 4'h0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dm_resp(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, dm_rdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, dm_rdata, e);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h010] = 32'h00500093;
    mem[14'h011] = 32'h11111111;
    mem[14'h020] = 32'hDEADBEEF;
    mem[14'h030] = 32'hAAAAAAAA;
    mem[14'h040] = 32'h40404040;
    mem[14'h041] = 32'h41414141;
    mem[14'h050] = 32'hCAFEBABE;

    // reset state, stalls follow requests
    idle_inputs();
    rst    = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    #2;
    chk("rst_if_stall", 32'(if_stall), 32'd1);
    chk("rst_dm_stall", 32'(dm_stall), 32'd1);
    chk("rst_cs", 32'(sram_cs), 32'd0);
    chk("rst_oe", 32'(sram_oe), 32'd0);
    chk("rst_web", 32'(sram_web), 32'hF);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_tag", 32'(dbg_tag), 32'(IDLE));
    cyc();
    rst = 1'b1;
    idle_inputs();

    // fetch only
    cyc();
    if_req  = 1'b1;
    if_addr = 14'h010;
    smp();
    chk("f1_cs", 32'(sram_cs), 32'd1);
    chk("f1_oe", 32'(sram_oe), 32'd1);
    chk("f1_a", 32'(sram_a), 32'h010);
    chk("f1_stall", 32'(if_stall), 32'd0);
    chk("f1_rvalid", 32'(if_rvalid), 32'd0);
    for (int k = 2; k <= 3; k++) begin
      cyc();
      smp();
      chk("f_cs", 32'(sram_cs), 32'd1);
      chk("f_stall", 32'(if_stall), 32'd0);
      chk("f_rvalid", 32'(if_rvalid), 32'd1);
      chk("f_rdata", if_rdata, 32'h00500093);
    end
    cyc();
    if_req = 1'b0;
    smp();
    chk("f4_rvalid", 32'(if_rvalid), 32'd1);
    chk("f4_cs", 32'(sram_cs), 32'd0);
    cyc();
    smp();
    chk("f5_rvalid", 32'(if_rvalid), 32'd0);
    chk("f5_hold", if_rdata, 32'h00500093);

    // conflict: data wins, fetch served next
    cyc();
    dm_req  = 1'b1;
    dm_addr = 14'h020;
    if_req  = 1'b1;
    if_addr = 14'h011;
    exp_q.push_back(32'hDEADBEEF);
    smp();
    chk("c1_a", 32'(sram_a), 32'h020);
    chk("c1_if_stall", 32'(if_stall), 32'd1);
    chk("c1_dm_stall", 32'(dm_stall), 32'd0);
    cyc();
    dm_req = 1'b0;
    smp();
    chk("c2_dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk_dm_resp("c2_dm_rdata");
    chk("c2_a", 32'(sram_a), 32'h011);
    chk("c2_if_stall", 32'(if_stall), 32'd0);
    cyc();
    if_req = 1'b0;
    smp();
    chk("c3_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("c3_if_rdata", if_rdata, 32'h11111111);
    chk("c3_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("c3_dm_hold", dm_rdata, 32'hDEADBEEF);

    // byte write then read back
    cyc();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_wen   = 4'b0011;
    dm_addr  = 14'h030;
    dm_wdata = 32'h12345678;
    smp();
    chk("w_web", 32'(sram_web), 32'hC);
    chk("w_oe", 32'(sram_oe), 32'd0);
    chk("w_di", sram_di, 32'h12345678);
    chk("w_dm_rvalid", 32'(dm_rvalid), 32'd0);
    // enables all low: a granted write that changes nothing
    cyc();
    dm_wen   = 4'b0000;
    dm_wdata = 32'hFFFFFFFF;
    smp();
    chk("w0_cs", 32'(sram_cs), 32'd1);
    chk("w0_web", 32'(sram_web), 32'hF);
    chk("w0_dm_rvalid", 32'(dm_rvalid), 32'd0);
    cyc();
    dm_we = 1'b0;
    exp_q.push_back(32'hAAAA5678);
    smp();
    chk("r_oe", 32'(sram_oe), 32'd1);
    chk("r_dm_rvalid", 32'(dm_rvalid), 32'd0);
    cyc();
    dm_req = 1'b0;
    smp();
    chk("r_dm_rvalid2", 32'(dm_rvalid), 32'd1);
    chk_dm_resp("r_dm_rdata");

    // starvation guard
    cyc();
    dm_req  = 1'b1;
    dm_addr = 14'h040;
    if_req  = 1'b1;
    if_addr = 14'h041;
    for (int k = 1; k <= 10; k++) begin
      smp();
      chk($sformatf("s%0d_if_stall", k), 32'(if_stall), (k == 5 || k == 10) ? 32'd0 : 32'd1);
      chk($sformatf("s%0d_dm_stall", k), 32'(dm_stall), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      if (k == 6) begin
        chk("s6_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("s6_if_rdata", if_rdata, 32'h41414141);
      end
      cyc();
    end
    idle_inputs();

    // hold of fetch data across idle cycles and data-port traffic
    if_req  = 1'b1;
    if_addr = 14'h050;
    smp();
    chk("h_a", 32'(sram_a), 32'h050);
    cyc();
    if_req  = 1'b0;
    dm_req  = 1'b1;
    dm_addr = 14'h020;
    exp_q.push_back(32'hDEADBEEF);
    smp();
    chk("h1_rvalid", 32'(if_rvalid), 32'd1);
    chk("h1_rdata", if_rdata, 32'hCAFEBABE);
    cyc();
    dm_req = 1'b0;
    smp();
    chk_dm_resp("h2_dm_rdata");
    for (int k = 2; k <= 6; k++) begin
      chk($sformatf("h%0d_rvalid", k), 32'(if_rvalid), 32'd0);
      chk($sformatf("h%0d_rdata", k), if_rdata, 32'hCAFEBABE);
      cyc();
      smp();
    end

    // reset while a fetch read is in flight
    cyc();
    if_req  = 1'b1;
    if_addr = 14'h010;
    smp();
    chk("x_cs", 32'(sram_cs), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("x_rvalid", 32'(if_rvalid), 32'd0);
    chk("x_rdata", if_rdata, 32'd0);
    chk("x_tag", 32'(dbg_tag), 32'(IDLE));
    chk("x_web", 32'(sram_web), 32'hF);
    chk("x_cs_rst", 32'(sram_cs), 32'd0);
    chk("x_stall", 32'(if_stall), 32'd1);
    cyc();
    rst = 1'b1;
    idle_inputs();
    smp();
    chk("xr_rvalid", 32'(if_rvalid), 32'd0);
    chk("xr_rdata", if_rdata, 32'd0);
    chk("xr_cs", 32'(sram_cs), 32'd0);
    cyc();
    smp();
    chk("xr2_rvalid", 32'(if_rvalid), 32'd0);
    chk("xr2_tag", 32'(dbg_tag), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
